cla_pipe_adder: RTL and testbench

Parametrised, two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes on input and output. It generalises the team's 4-bit lookahead unit to any width that is a multiple of 4. It uses a two-level group-generate/propagate tree, and adds subtract mode, signed/unsigned flags and optional saturation. It sits between operand-fetch and writeback as the shared ALU add path.

---
 rtl/cla_pkg.sv | 26 ++
 rtl/cla_group4.sv | 22 ++
 rtl/cla_pipe_adder.sv | 148 ++++++++++++++
 tb/tb_cla_pipe_adder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants, 4-bit group generate/propagate helpers and the stage-1 control payload
// for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int CLA_GROUP = 4;

  function automatic int cla_ngroups(input int width);
    return width / CLA_GROUP;
  endfunction

  // Bit 0's propagate never enters the group generate term, so only p[3:1] is taken.
  function automatic logic grp_g(input logic [3:0] g, input logic [3:1] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  function automatic logic grp_p(input logic [3:0] p);
    return &p;
  endfunction

  typedef struct packed {
    logic c0;
    logic sub;
    logic sgn;
  } s1_ctl_t;

endpackage

// File: rtl/cla_group4.sv
// 4-bit lookahead group: internal carries from the group carry-in, plus group G/P.
// Purely combinational; c[0] is the group carry-in itself.
module cla_group4
  import cla_pkg::*;
(
  input  logic       ci,
  input  logic [3:0] g,
  input  logic [3:0] p,
  output logic [3:0] c,
  output logic       gg,
  output logic       pp
);

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

  assign gg = grp_g(g, p[3:1]);
  assign pp = grp_p(p);

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage carry-lookahead add/sub, 2-cycle latency, 1 beat/cycle; in_ready = stage-1 can advance.
// Build option CLA_SAT_EN: saturate the sum on overflow (cout/ofl stay raw).
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ofl,
  output logic             zero
);

  localparam int NG = cla_ngroups(WIDTH);

  logic             s1_valid, s1_adv, s2_adv;
  logic [WIDTH-1:0] bx, bg, bp;
  logic [NG-1:0]    bgg, bpp;
  s1_ctl_t          ctl;

  logic [WIDTH-1:0] s1_a, s1_bx, s1_g, s1_p;
  logic [NG-1:0]    s1_gg, s1_pp;
  s1_ctl_t          s1_ctl;

  logic [NG:0]      gc;
  logic [WIDTH:0]   c;
  logic [NG-1:0]    s2_gg, s2_pp;
  logic [WIDTH-1:0] raw, res;
  logic             raw_cout, raw_ofl;
  logic             unused_s2;

  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv;

  // Stage 1: effective operand, bit and group generate/propagate.
  assign bx  = sub ? ~b : b;
  assign bg  = a & bx;
  assign bp  = a ^ bx;
  assign ctl = {sub | cin, sub, sgn};

  for (genvar k = 0; k < NG; k++) begin : g_s1
    assign bgg[k] = grp_g(bg[CLA_GROUP*k +: 4], bp[CLA_GROUP*k+1 +: 3]);
    assign bpp[k] = grp_p(bp[CLA_GROUP*k +: 4]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && s1_adv && in_valid) begin
      s1_a   <= a;
      s1_bx  <= bx;
      s1_g   <= bg;
      s1_p   <= bp;
      s1_gg  <= bgg;
      s1_pp  <= bpp;
      s1_ctl <= ctl;
    end
  end

  // Stage 2: flat sum-of-products group carries, so no carry ripples between groups.
  always_comb begin
    logic acc;
    logic term;
    acc   = 1'b0;
    term  = 1'b0;
    gc    = '0;
    gc[0] = s1_ctl.c0;
    for (int k = 0; k < NG; k++) begin
      acc = s1_ctl.c0;
      for (int j = 0; j <= k; j++) acc = acc & s1_pp[j];
      for (int j = 0; j <= k; j++) begin
        term = s1_gg[j];
        for (int m = j + 1; m <= k; m++) term = term & s1_pp[m];
        acc = acc | term;
      end
      gc[k+1] = acc;
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_s2
    cla_group4 u_grp (
      .ci (gc[k]),
      .g  (s1_g[CLA_GROUP*k +: 4]),
      .p  (s1_p[CLA_GROUP*k +: 4]),
      .c  (c[CLA_GROUP*k +: 4]),
      .gg (s2_gg[k]),
      .pp (s2_pp[k])
    );
  end

  assign c[WIDTH] = gc[NG];

  // Group G/P are taken from the stage-1 registers; the recomputed copies and the raw operands
  // are kept only for visibility.
  assign unused_s2 = ^{s1_a, s1_bx, s2_gg, s2_pp};

  always_comb begin
    raw      = s1_p ^ c[WIDTH-1:0];
    raw_cout = c[WIDTH];
    if (s1_ctl.sgn) raw_ofl = c[WIDTH-1] ^ c[WIDTH];
    else            raw_ofl = s1_ctl.sub ? ~c[WIDTH] : c[WIDTH];
    res = raw;
`ifdef CLA_SAT_EN
    // Signed overflow needs same-sign operands, so a's sign picks the clamp direction.
    if (raw_ofl) begin
      if (s1_ctl.sgn) res = s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else            res = s1_ctl.sub ? '0 : '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ofl       <= 1'b0;
      zero      <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= res;
        cout <= raw_cout;
        ofl  <= raw_ofl;
        zero <= (res == '0);
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and randomized checks of cla_pipe_adder against an arithmetic reference model.
module tb_cla_pipe_adder;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ofl;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, sub, sgn;
  logic         out_valid, out_ready, cout, ofl, zero;
  logic [W-1:0] a, b, sum;

  int   npass = 0;
  int   ntot  = 0;
  int   cnt;
  exp_t exp_q[$];
  exp_t pend;
  logic lastir, lastov, acc, rst_seen;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ofl       (ofl),
    .zero      (zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic of, input logic z);
    exp_t e;
    e.sum = s; e.cout = co; e.ofl = of; e.zero = z;
    return e;
  endfunction

  // Reference: plain wide addition of the effective operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic su, input logic sg);
    logic [W-1:0] yx;
    logic [W:0]   full;
    exp_t         e;
    yx     = su ? ~y : y;
    full   = {1'b0, x} + {1'b0, yx} + {{W{1'b0}}, (su ? 1'b1 : ci)};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    if (sg) e.ofl = (x[W-1] == yx[W-1]) && (full[W-1] != x[W-1]);
    else    e.ofl = su ? !full[W] : full[W];
`ifdef CLA_SAT_EN
    if (e.ofl) begin
      if (sg) e.sum = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else    e.sum = su ? '0 : '1;
    end
`endif
    e.zero = (e.sum == '0);
    return e;
  endfunction

  // One clock: observe at negedge, score drained results, log accepted beats.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    lastir = in_ready;
    lastov = out_valid;
    acc    = 1'b0;
    if (rst_seen) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_flags", {cout, ofl, zero}, 0);
    end
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stale_out", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sum", sum, e.sum);
          chk("cout_ofl_zero", {cout, ofl, zero}, {e.cout, e.ofl, e.zero});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(pend);
        acc = 1'b1;
      end
    end
    @(posedge clk);
    rst_seen = rst;
    #1;
  endtask

  task automatic offer(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       input logic su, input logic sg, input exp_t e, input bit rnd_rdy);
    a = x; b = y; cin = ci; sub = su; sgn = sg; pend = e; in_valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    if (!acc) chk("accept_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic lat_check(input string tag);
    cyc();
    chk({tag, "_n1"}, lastov, 0);
    cyc();
    chk({tag, "_n2"}, lastov, 1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs, rg;

    rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h1111;
    cin = 1'b0; sub = 1'b0; sgn = 1'b0; out_ready = 1'b1; pend = '0;
    @(posedge clk);
    rst_seen = 1'b1;
    #1;
    cyc();
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    cyc();
    chk("ready_after_rst", lastir, 1);
    repeat (3) cyc();

`ifdef CLA_SAT_EN
    offer(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, mk(16'hFFFF, 1'b1, 1'b1, 1'b0), 1'b0);
    lat_check("carry_chain");
    offer(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h7FFF, 1'b0, 1'b1, 1'b0), 1'b0);
    lat_check("signed_ofl");
    offer(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, mk(16'h0000, 1'b0, 1'b1, 1'b1), 1'b0);
    lat_check("sub_unsigned");
`else
    offer(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b1, 1'b1), 1'b0);
    lat_check("carry_chain");
    offer(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h8000, 1'b0, 1'b1, 1'b0), 1'b0);
    lat_check("signed_ofl");
    offer(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, mk(16'hFFFE, 1'b0, 1'b1, 1'b0), 1'b0);
    lat_check("sub_unsigned");
`endif
    offer(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0), 1'b0);
    lat_check("sub_signed");

    // Back-pressure: consumer stalls for the first 3 cycles of a 4-beat stream.
    cnt = 0;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      a = W'(i); b = W'(i); cin = 1'b0; sub = 1'b0; sgn = 1'b0;
      pend = mk(W'(2 * i), 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      acc = 1'b0;
      for (int n = 0; n < 20 && !acc; n++) begin
        out_ready = (cnt >= 3);
        cyc();
        if (cnt == 2) chk("bp_in_ready_low", lastir, 0);
        cnt++;
      end
      if (!acc) chk("bp_accept_timeout", acc, 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    chk("bp_drained", exp_q.size(), 0);

    // Reset with two beats held in the pipe.
    out_ready = 1'b0;
    offer(16'h000A, 16'h000A, 1'b0, 1'b0, 1'b0, mk(16'h0014, 1'b0, 1'b0, 1'b0), 1'b0);
    offer(16'h0014, 16'h0014, 1'b0, 1'b0, 1'b0, mk(16'h0028, 1'b0, 1'b0, 1'b0), 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0; out_ready = 1'b1;
    offer(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, mk(16'h0007, 1'b0, 1'b0, 1'b0), 1'b0);
    lat_check("post_rst");
    repeat (3) cyc();

    for (int i = 0; i < 150; i++) begin
      ra = pick(); rb = pick();
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      rg = 1'($urandom_range(0, 1));
      offer(ra, rb, rc, rs, rg, model(ra, rb, rc, rs, rg), 1'b1);
      if ($urandom_range(0, 3) == 0) cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) cyc();
    chk("final_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
